// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the system-memory arbiter.
// Holds the FSM state type and the grant-index width helper.
package mem_arb_pkg;

  localparam int N_DEF  = 4;
  localparam int AN_DEF = 24;
  localparam int DN_DEF = 16;
  localparam int RD_DEF = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  function automatic int gw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_arb_tag_fifo.sv
// In-order tag FIFO recording which requester owns each outstanding read.
// Push and pop in one cycle are both honoured, so occupancy holds.
module mem_arb_tag_fifo #(
  parameter int TW = 2,
  parameter int RD = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [TW-1:0] din,
  output logic [TW-1:0] dout,
  output logic          full,
  output logic          empty
);

  localparam int PW = (RD > 1) ? $clog2(RD) : 1;
  localparam int CW = $clog2(RD) + 1;

  logic [TW-1:0] mem [RD];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic [CW-1:0] cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == CW'(RD));
  assign empty   = (cnt == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rp];

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + PW'(1);
      if (do_pop)  rp <= rp + PW'(1);
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port among N requesters; reads return via a tag FIFO.
// Define ARB_ROUND_ROBIN_EN for round-robin, else fixed priority (0 highest).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int AN = AN_DEF,
  parameter int DN = DN_DEF,
  parameter int RD = RD_DEF
) (
  input  logic          clkSYS,
  input  logic          reset,
  input  logic [N-1:0]  req_i,
  input  logic [N*AN-1:0] addr_i,
  input  logic [N*DN-1:0] data_i,
  input  logic [N-1:0]  wr_i,
  output logic [N-1:0]  ack_o,
  output logic [N-1:0]  rvalid_o,
  output logic [DN-1:0] rdata_o,
  output logic          mem_req,
  output logic [AN-1:0] mem_addr,
  output logic [DN-1:0] mem_data,
  output logic          mem_wr,
  input  logic          mem_ack,
  input  logic          mem_rvalid,
  input  logic [DN-1:0] mem_rdata,
  output logic          err
);

  localparam int GW = gw(N);

  state_t        state;
  logic [GW-1:0] g;
  logic [GW-1:0] sel;
  logic          any;
  logic [N-1:0]  elig;
  logic          full;
  logic          empty;
  logic          push;
  logic [GW-1:0] tag;
  logic [N-1:0]  rv_next;
  logic          done;

  // A read may only start if its tag has somewhere to go
  assign elig = req_i & (wr_i | {N{~full}});
  assign done = (state == GRANT) && mem_ack;
  assign push = done && !mem_wr;
  assign mem_req = (state == GRANT);

`ifdef ARB_ROUND_ROBIN_EN
  logic [GW-1:0] ptr;

  always_comb begin
    int k;
    sel = '0;
    any = 1'b0;
    for (int i = 0; i < N; i++) begin
      k = (int'(ptr) + i) % N;
      if (!any && elig[k]) begin
        sel = GW'(k);
        any = 1'b1;
      end
    end
  end

  always_ff @(posedge clkSYS) begin
    if (reset) begin
      ptr <= '0;
    end else if (done) begin
      ptr <= (g == GW'(N - 1)) ? '0 : g + GW'(1);
    end
  end
`else
  always_comb begin
    sel = '0;
    any = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (elig[i]) begin
        sel = GW'(i);
        any = 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge clkSYS) begin
    if (reset) begin
      state    <= IDLE;
      g        <= '0;
      mem_addr <= '0;
      mem_data <= '0;
      mem_wr   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any) begin
            state    <= GRANT;
            g        <= sel;
            mem_addr <= addr_i[sel*AN +: AN];
            mem_data <= data_i[sel*DN +: DN];
            mem_wr   <= wr_i[sel];
          end
        end
        GRANT: begin
          if (mem_ack) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    ack_o = '0;
    if (done) ack_o[g] = 1'b1;
  end

  mem_arb_tag_fifo #(
    .TW (GW),
    .RD (RD)
  ) u_fifo (
    .clk   (clkSYS),
    .reset (reset),
    .push  (push),
    .pop   (mem_rvalid),
    .din   (g),
    .dout  (tag),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    rv_next = '0;
    if (mem_rvalid && !empty) rv_next[tag] = 1'b1;
  end

  // Stray return data is discarded; only the sticky flag records it
  always_ff @(posedge clkSYS) begin
    if (reset) begin
      rvalid_o <= '0;
      rdata_o  <= '0;
      err      <= 1'b0;
    end else begin
      rvalid_o <= rv_next;
      if (mem_rvalid) begin
        if (empty) err <= 1'b1;
        else rdata_o <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised and directed bench for mem_arbiter against a queue-based model.
// Build with ARB_ROUND_ROBIN_EN to check the round-robin variant.
module tb_mem_arbiter;

  localparam int N  = 4;
  localparam int AN = 24;
  localparam int DN = 16;
  localparam int RD = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req;
  logic [N*AN-1:0] addr;
  logic [N*DN-1:0] data;
  logic [N-1:0]  wr;
  logic [N-1:0]  ack_o;
  logic [N-1:0]  rvalid_o;
  logic [DN-1:0] rdata_o;
  logic          mem_req;
  logic [AN-1:0] mem_addr;
  logic [DN-1:0] mem_data;
  logic          mem_wr;
  logic          mem_ack;
  logic          mem_rvalid;
  logic [DN-1:0] mem_rdata;
  logic          err;

  always #5 clk = ~clk;

  mem_arbiter #(.N(N), .AN(AN), .DN(DN), .RD(RD)) dut (
    .clkSYS     (clk),
    .reset      (reset),
    .req_i      (req),
    .addr_i     (addr),
    .data_i     (data),
    .wr_i       (wr),
    .ack_o      (ack_o),
    .rvalid_o   (rvalid_o),
    .rdata_o    (rdata_o),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_wr     (mem_wr),
    .mem_ack    (mem_ack),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .err        (err)
  );

  int tests = 0;
  int fails = 0;

  // reference model: one transaction in flight plus a queue of read owners
  bit            m_busy;
  int            m_cur;
  int            m_ptr;
  int            m_q[$];
  logic [N-1:0]  m_rv;
  logic [DN-1:0] m_rd;
  bit            m_err;
  logic [AN-1:0] m_addr;
  logic [DN-1:0] m_data;
  bit            m_wr;

  int           ack_mode;
  bit           hold;
  logic [N-1:0] dropped;
  int           ack_log[$];
  int           rv_idx[$];
  logic [DN-1:0] rv_dat[$];

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic set_req(input int k, input bit w,
                         input logic [AN-1:0] a, input logic [DN-1:0] d);
    req[k] = 1'b1;
    wr[k]  = w;
    addr[k*AN +: AN] = a;
    data[k*DN +: DN] = d;
  endtask

  task automatic model_cycle();
    bit full0;
    int pick;
    int k;
    full0 = (m_q.size() == RD);
    m_rv = '0;
    if (mem_rvalid) begin
      if (m_q.size() > 0) begin
        m_rv[m_q.pop_front()] = 1'b1;
        m_rd = mem_rdata;
      end else begin
        m_err = 1'b1;
      end
    end
    if (m_busy) begin
      if (mem_ack) begin
        if (!m_wr) m_q.push_back(m_cur);
        m_ptr  = (m_cur + 1) % N;
        m_busy = 1'b0;
      end
    end else begin
      pick = -1;
      for (int i = 0; i < N; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
        k = (m_ptr + i) % N;
`else
        k = i;
`endif
        if (pick < 0 && req[k] && (wr[k] || !full0)) pick = k;
      end
      if (pick >= 0) begin
        m_busy = 1'b1;
        m_cur  = pick;
        m_addr = addr[pick*AN +: AN];
        m_data = data[pick*DN +: DN];
        m_wr   = wr[pick];
      end
    end
  endtask

  // one clock: check outputs, advance model, requesters react to ack
  task automatic step();
    logic [N-1:0] ea;
    logic [N-1:0] drop;
    if (ack_mode == 1) mem_ack = mem_req;
    else if (ack_mode == 2)
      mem_ack = mem_req && ($urandom_range(1, 0) == 1);
    #1;
    ea = '0;
    if (m_busy && mem_ack) ea[m_cur] = 1'b1;
    check("mem_req", mem_req, m_busy);
    check("ack_o", ack_o, ea);
    check("rvalid_o", rvalid_o, m_rv);
    if (m_rv != '0) check("rdata_o", rdata_o, m_rd);
    check("err", err, m_err);
    if (m_busy) begin
      check("mem_addr", mem_addr, m_addr);
      check("mem_data", mem_data, m_data);
      check("mem_wr", mem_wr, m_wr);
    end
    if (ack_o != '0) ack_log.push_back(idx(ack_o));
    if (rvalid_o != '0) begin
      rv_idx.push_back(idx(rvalid_o));
      rv_dat.push_back(rdata_o);
    end
    drop = hold ? '0 : ack_o;
    if (reset) begin
      m_busy = 0; m_ptr = 0; m_q.delete();
      m_rv = '0; m_err = 0;
      m_addr = '0; m_data = '0; m_wr = 0;
    end else begin
      model_cycle();
    end
    @(posedge clk);
    @(negedge clk);
    req = req & ~drop;
    dropped = drop;
  endtask

  task automatic issue(input int k, input bit w,
                       input logic [AN-1:0] a, input logic [DN-1:0] d);
    int n;
    set_req(k, w, a, d);
    n = 0;
    while (req[k] && n < 20) begin
      step();
      n++;
    end
    if (req[k]) check("issue_timeout", 1, 0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_addr"}, mem_addr, 0);
    check({tag, "_data"}, mem_data, 0);
    check({tag, "_wr"}, mem_wr, 0);
    check({tag, "_req"}, mem_req, 0);
    check({tag, "_rv"}, rvalid_o, 0);
    check({tag, "_err"}, err, 0);
  endtask

  int seq[5];
  int n;

  initial begin
    reset = 1'b1; req = '0; wr = '0; addr = '0; data = '0;
    mem_ack = 0; mem_rvalid = 0; mem_rdata = '0;
    ack_mode = 0; hold = 0; dropped = '0;
    m_busy = 0; m_cur = 0; m_ptr = 0; m_rv = '0; m_rd = '0;
    m_err = 0; m_addr = '0; m_data = '0; m_wr = 0;
    @(negedge clk);
    step();
    step();
    reset = 1'b0;
    check_zero("rst");

    // single write, memory acks 3 cycles after mem_req
    set_req(2, 1, 24'h000100, 16'hABCD);
    step();
    step(); step(); step();
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    step();
    step();
    check("wr_ack_cnt", ack_log.size(), 1);
    if (ack_log.size() == 1) check("wr_ack_idx", ack_log[0], 2);
    ack_log.delete();

    // contention with all requests held
    hold = 1; ack_mode = 1;
    for (int k = 0; k < N; k++) set_req(k, 1, AN'(k * 16), DN'(k));
    repeat (12) step();
    req = '0; hold = 0;
    repeat (3) step();
`ifdef ARB_ROUND_ROBIN_EN
    seq = '{0, 1, 2, 3, 0};
`else
    seq = '{0, 0, 0, 0, 0};
`endif
    check("arb_cnt", ack_log.size() >= 5, 1);
    for (int i = 0; i < 5; i++)
      if (i < ack_log.size()) check("arb_seq", ack_log[i], seq[i]);

    // read tagging
    rv_idx.delete(); rv_dat.delete();
    issue(1, 0, 24'h000010, '0);
    issue(3, 0, 24'h000030, '0);
    mem_rvalid = 1'b1; mem_rdata = 16'h1111;
    step();
    mem_rdata = 16'h2222;
    step();
    mem_rvalid = 1'b0;
    step(); step();
    check("tag_cnt", rv_idx.size(), 2);
    if (rv_idx.size() == 2) begin
      check("tag0_idx", rv_idx[0], 1);
      check("tag0_dat", rv_dat[0], 16'h1111);
      check("tag1_idx", rv_idx[1], 3);
      check("tag1_dat", rv_dat[1], 16'h2222);
    end

    // fill the tag FIFO, then a blocked read races a write
    repeat (RD) issue(0, 0, 24'h000400, '0);
    ack_log.delete();
    set_req(0, 0, 24'h000500, '0);
    set_req(1, 1, 24'h000600, 16'h5A5A);
    repeat (6) step();
    check("full_acks", ack_log.size(), 1);
    if (ack_log.size() > 0) check("full_wr_first", ack_log[0], 1);
    mem_rvalid = 1'b1; mem_rdata = 16'h0F0F;
    step();
    mem_rvalid = 1'b0;
    n = 0;
    while (req[0] && n < 10) begin step(); n++; end
    check("unblock", req[0], 0);
    mem_rvalid = 1'b1; mem_rdata = 16'h1234;
    step();
    mem_rvalid = 1'b0;
    // ack and return in the same cycle
    ack_mode = 0;
    set_req(2, 0, 24'h000700, '0);
    step(); step();
    mem_ack = 1'b1; mem_rvalid = 1'b1; mem_rdata = 16'h4321;
    step();
    mem_ack = 1'b0; mem_rvalid = 1'b0;
    step();

    // randomised traffic
    ack_mode = 2;
    repeat (1500) begin
      for (int k = 0; k < N; k++)
        if (!req[k] && !dropped[k] && $urandom_range(3, 0) == 0)
          set_req(k, 1'($urandom_range(1, 0)), AN'($urandom), DN'($urandom));
      mem_rvalid = (m_q.size() > 0) && ($urandom_range(2, 0) == 0);
      mem_rdata = DN'($urandom);
      step();
    end
    ack_mode = 1;
    n = 0;
    while ((req != '0 || m_busy || m_q.size() > 0) && n < 200) begin
      mem_rvalid = (m_q.size() > 0);
      mem_rdata = DN'($urandom);
      step();
      n++;
    end
    check("drain", n < 200, 1);
    mem_rvalid = 1'b0; ack_mode = 0; mem_ack = 1'b0;
    step();

    // stray return data
    mem_rvalid = 1'b1; mem_rdata = 16'hDEAD;
    step();
    mem_rvalid = 1'b0;
    step(); step();
    check("stray_err", err, 1);
    check("stray_rv", rvalid_o, 0);

    // reset while a read is being presented
    set_req(2, 0, 24'h000222, '0);
    step(); step();
    reset = 1'b1; req = '0;
    step();
    reset = 1'b0;
    check_zero("rst2");
    step();
    mem_rvalid = 1'b1;
    step();
    mem_rvalid = 1'b0;
    step();
    check("late_err", err, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
